// File: rtl/gcd_datapath.sv
// Operand/arithmetic stage beneath gcd_fsm: operand capture, subtractive Euclid, result handshake.
// Define GCD_STEP_COUNT_EN to add the saturating step_count_o counter.
module gcd_datapath #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 gcd_enable_i,
    input  logic [WIDTH-1:0]     operand_a_i,
    input  logic [WIDTH-1:0]     operand_b_i,
    input  logic                 operands_valid_i,
    output logic                 operands_ready_o,
    input  logic                 flag_init_i,
    input  logic                 flag_compute_i,
    input  logic                 flag_finish_i,
    output logic                 compute_enable_o,
    output logic                 compare_zero_o,
    output logic [WIDTH-1:0]     result_o,
    output logic                 result_valid_o,
    input  logic                 result_ready_i
`ifdef GCD_STEP_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] step_count_o
`endif
);

    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q;
    logic             loaded_q;
    logic             done_q;
    logic             result_valid_q;
    logic             a_zero, b_zero;
    logic             load_en;
    logic             step_en;

    assign a_zero           = (a_q == '0);
    assign b_zero           = (b_q == '0);
    assign operands_ready_o = flag_init_i & ~loaded_q;
    assign compute_enable_o = flag_init_i & loaded_q & ~a_zero & ~b_zero;
    assign compare_zero_o   = loaded_q & (a_zero | b_zero);
    assign load_en          = gcd_enable_i & operands_valid_i & operands_ready_o;
    assign step_en          = gcd_enable_i & flag_compute_i & loaded_q & ~compare_zero_o;
    assign result_o         = result_q;
    assign result_valid_o   = result_valid_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            a_q      <= '0;
            b_q      <= '0;
            loaded_q <= 1'b0;
        end else if (load_en) begin
            a_q      <= operand_a_i;
            b_q      <= operand_b_i;
            loaded_q <= 1'b1;
        end else if (step_en) begin
            // Equal operands: clearing b ends the run with the gcd left in a.
            if (a_q > b_q) begin
                a_q <= a_q - b_q;
            end else if (b_q > a_q) begin
                b_q <= b_q - a_q;
            end else begin
                b_q <= '0;
            end
        end
    end

    // One-shot result: done_q prevents re-issue until the next reset.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else if (gcd_enable_i) begin
            if (flag_finish_i && !done_q) begin
                done_q         <= 1'b1;
                result_valid_q <= 1'b1;
                result_q       <= a_q | b_q;
            end else if (result_valid_q && result_ready_i) begin
                result_valid_q <= 1'b0;
                result_q       <= '0;
            end
        end
    end

`ifdef GCD_STEP_COUNT_EN
    logic [CNT_WIDTH-1:0] step_cnt_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            step_cnt_q <= '0;
        end else if (step_en && (step_cnt_q != {CNT_WIDTH{1'b1}})) begin
            step_cnt_q <= step_cnt_q + 1'b1;
        end
    end

    assign step_count_o = step_cnt_q;
`endif

endmodule

// File: tb/tb_gcd_datapath.sv
// Self-checking bench for gcd_datapath with a small behavioural stand-in for gcd_fsm.
module tb_gcd_datapath;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          en = 1'b1;
    logic [W-1:0]  operand_a = '0, operand_b = '0;
    logic          operands_valid = 1'b0;
    logic          operands_ready;
    logic          flag_init, flag_compute, flag_finish;
    logic          compute_enable, compare_zero;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          result_ready = 1'b0;
`ifdef GCD_STEP_COUNT_EN
    logic [CW-1:0] step_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gcd_datapath #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk_i            (clk),
        .nreset_i         (nreset),
        .gcd_enable_i     (en),
        .operand_a_i      (operand_a),
        .operand_b_i      (operand_b),
        .operands_valid_i (operands_valid),
        .operands_ready_o (operands_ready),
        .flag_init_i      (flag_init),
        .flag_compute_i   (flag_compute),
        .flag_finish_i    (flag_finish),
        .compute_enable_o (compute_enable),
        .compare_zero_o   (compare_zero),
        .result_o         (result),
        .result_valid_o   (result_valid),
        .result_ready_i   (result_ready)
`ifdef GCD_STEP_COUNT_EN
        ,
        .step_count_o     (step_count)
`endif
    );

    // Stand-in controller: INIT -> COMPUTE -> FINISH, or INIT -> FINISH on zero operands.
    typedef enum logic [1:0] {FInit, FCompute, FFinish} fsm_t;
    fsm_t st;
    logic ce_seen;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            st      <= FInit;
            ce_seen <= 1'b0;
        end else begin
            if (compute_enable) ce_seen <= 1'b1;
            if (en) begin
                case (st)
                    FInit:    if (compute_enable) st <= FCompute;
                              else if (compare_zero) st <= FFinish;
                    FCompute: if (compare_zero) st <= FFinish;
                    default:  ;
                endcase
            end
        end
    end

    assign flag_init    = (st == FInit);
    assign flag_compute = (st == FCompute);
    assign flag_finish  = (st == FFinish);

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: Euclid via division; a quotient q of whole subtractions costs q steps.
    task automatic ref_gcd(input int unsigned a_in, input int unsigned b_in,
                           output int unsigned g, output int unsigned steps);
        int unsigned a, b, q, r;
        a = a_in;
        b = b_in;
        steps = 0;
        while (a != 0 && b != 0) begin
            if (a == b) begin
                steps += 1;
                b = 0;
            end else if (a > b) begin
                q = a / b;
                r = a % b;
                steps += q;
                if (r == 0) begin
                    a = b;
                    b = 0;
                end else begin
                    a = r;
                end
            end else begin
                q = b / a;
                r = b % a;
                steps += q;
                b = r;
            end
        end
        g = (a > b) ? a : b;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        en = 1'b1;
        operands_valid = 1'b0;
        result_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_operands_ready", operands_ready, 1);
        check("rst_compute_enable", compute_enable, 0);
        check("rst_compare_zero", compare_zero, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result", result, 0);
`ifdef GCD_STEP_COUNT_EN
        check("rst_step_count", step_count, 0);
`endif
        nreset = 1'b1;
    endtask

    task automatic run_pair(input int unsigned a, input int unsigned b, input int unsigned exp_res,
                            input int unsigned exp_steps, input int unsigned hold);
        int  cyc;
        bit  got;
        do_reset();
        result_ready = (hold == 0);
        @(negedge clk);
        operand_a = W'(a);
        operand_b = W'(b);
        operands_valid = 1'b1;
        check("ready_before_accept", operands_ready, 1);
        @(negedge clk);
        operands_valid = 1'b0;
        check("ready_after_accept", operands_ready, 0);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (result_valid) got = 1'b1;
        end
        check($sformatf("result_seen_%0d_%0d", a, b), got, 1);
        if (got) begin
            check($sformatf("result_%0d_%0d", a, b), result, exp_res);
            if (a != 0 && b != 0) check($sformatf("latency_%0d_%0d", a, b), cyc, exp_steps + 3);
            else check($sformatf("no_compute_enable_%0d_%0d", a, b), ce_seen, 0);
`ifdef GCD_STEP_COUNT_EN
            check($sformatf("steps_%0d_%0d", a, b), step_count,
                  (exp_steps > CNT_MAX) ? CNT_MAX : exp_steps);
`endif
            for (int i = 0; i < int'(hold); i++) begin
                check("held_valid", result_valid, 1);
                check("held_result", result, exp_res);
                @(negedge clk);
            end
            result_ready = 1'b1;
            @(negedge clk);
            check("cleared_valid", result_valid, 0);
            check("cleared_result", result, 0);
            // A second operand pair must be refused and the result never re-issued.
            operand_a = 16'd7;
            operand_b = 16'd3;
            operands_valid = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check("second_pair_refused", operands_ready, 0);
                check("no_reissue", result_valid, 0);
            end
            operands_valid = 1'b0;
            result_ready = 1'b0;
        end
    endtask

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned res;
        int unsigned steps;
        int unsigned hold;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int unsigned ra, rb, rg, rs;
        int cyc;
        bit got;

        vecs[0] = '{a: 48,  b: 18,  res: 6,   steps: 5, hold: 0};
        vecs[1] = '{a: 0,   b: 35,  res: 35,  steps: 0, hold: 0};
        vecs[2] = '{a: 0,   b: 0,   res: 0,   steps: 0, hold: 0};
        vecs[3] = '{a: 255, b: 255, res: 255, steps: 1, hold: 0};
        vecs[4] = '{a: 48,  b: 18,  res: 6,   steps: 5, hold: 8};
        vecs[5] = '{a: 35,  b: 0,   res: 35,  steps: 0, hold: 2};
        vecs[6] = '{a: 17,  b: 5,   res: 1,   steps: 7, hold: 0};
        vecs[7] = '{a: 100, b: 75,  res: 25,  steps: 4, hold: 1};
        vecs[8] = '{a: 7,   b: 21,  res: 7,   steps: 3, hold: 0};

        for (int i = 0; i < 9; i++)
            run_pair(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].steps, vecs[i].hold);

        // Enable dropped for 10 cycles after the second step.
        do_reset();
        result_ready = 1'b1;
        @(negedge clk);
        operand_a = 16'd48;
        operand_b = 16'd18;
        operands_valid = 1'b1;
        @(negedge clk);
        operands_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_freeze_a", dut.a_q, 12);
        check("pre_freeze_b", dut.b_q, 18);
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("frozen_a", dut.a_q, 12);
            check("frozen_b", dut.b_q, 18);
            check("frozen_no_result", result_valid, 0);
        end
        en = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (result_valid) got = 1'b1;
        end
        check("resume_result_seen", got, 1);
        check("resume_result", result, 6);
        check("resume_latency", cyc, 5);
`ifdef GCD_STEP_COUNT_EN
        check("resume_steps", step_count, 5);
`endif
        @(negedge clk);
        check("resume_cleared", result_valid, 0);

        // Reset asserted in the middle of a computation.
        do_reset();
        @(negedge clk);
        operand_a = 16'd48;
        operand_b = 16'd18;
        operands_valid = 1'b1;
        @(negedge clk);
        operands_valid = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("midrst_ready", operands_ready, 1);
        check("midrst_compute_enable", compute_enable, 0);
        check("midrst_compare_zero", compare_zero, 0);
        check("midrst_result_valid", result_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_a", dut.a_q, 0);
        check("midrst_b", dut.b_q, 0);
        run_pair(1000, 1, 1, 1000, 0);

        // Randomised pairs against the reference model.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            if (i % 8 == 3) ra = 0;
            ref_gcd(ra, rb, rg, rs);
            run_pair(ra, rb, rg, rs, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
